// File: rtl/aes_enc_round_core.sv
// rtl/aes_enc_round_core.sv - iterative AES-128 encryption round datapath, one round per clock
//
// Purpose: takes a 128-bit plaintext as four 32-bit columns. It performs the initial
// AddRoundKey on the start edge. It then runs rounds 1..10 on the next ten edges.
// Round keys come from the external key store through rk_idx/rk.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   start            block request, sampled only while idle
//   w0..w3           plaintext columns 0..3 (byte [31:24] = row 0)
//   rk               round key for rk_idx, packed {col0,col1,col2,col3}
//   rk_idx           round-key index requested this cycle (0..10)
//   busy             high while rounds are in progress
//   done             one-cycle pulse when w_0..w_3 carry a new ciphertext
//   w_0..w_3         registered ciphertext columns, held until the next completion
//
// Optional build macro AES_ENC_DBG_EN adds two outputs:
//   dbg_state        current internal state register (128 bits)
//   dbg_round        current round counter (4 bits)

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];
endmodule

module aes_enc_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  w0,
    input  logic [31:0]  w1,
    input  logic [31:0]  w2,
    input  logic [31:0]  w3,
    input  logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [31:0]  w_0,
    output logic [31:0]  w_1,
    output logic [31:0]  w_2,
    output logic [31:0]  w_3
`ifdef AES_ENC_DBG_EN
    ,
    output logic [127:0] dbg_state,
    output logic [3:0]   dbg_round
`endif
);
    typedef enum logic {IDLE, ROUND} fsm_t;

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [3:0]   round_q;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_col[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mix_col[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mix_col[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mix_col[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    endfunction

    // Byte index i = 4*col + row sits at state[127-8*i -: 8].
    genvar gi, gc, gr;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            aes_sbox u_sbox (
                .a (state_q[127-8*gi -: 8]),
                .y (sb[127-8*gi -: 8])
            );
        end

        // Row r of output column c comes from input column (c+r) mod 4.
        for (gc = 0; gc < 4; gc++) begin : g_shift_col
            for (gr = 0; gr < 4; gr++) begin : g_shift_row
                assign sr[127-8*(4*gc+gr) -: 8] = sb[127-8*(4*((gc+gr)%4)+gr) -: 8];
            end
        end

        for (gc = 0; gc < 4; gc++) begin : g_mix
            assign mc[127-32*gc -: 32] = mix_col(sr[127-32*gc -: 32]);
        end
    endgenerate

    // The final round skips MixColumns.
    assign round_out = ((round_q == 4'd10) ? sr : mc) ^ rk;

    // round_q is 0 in IDLE and in the done cycle, so it doubles as the key request index.
    assign rk_idx = round_q;

`ifdef AES_ENC_DBG_EN
    assign dbg_state = state_q;
    assign dbg_round = round_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= 128'h0;
            round_q <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w_0     <= 32'h0;
            w_1     <= 32'h0;
            w_2     <= 32'h0;
            w_3     <= 32'h0;
        end else begin
            done <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= {w0, w1, w2, w3} ^ rk;
                        round_q <= 4'd1;
                        busy    <= 1'b1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    if (round_q == 4'd0) begin
                        // Done cycle: stay out of IDLE for it so a start in this cycle is ignored.
                        fsm_q <= IDLE;
                    end else begin
                        state_q <= round_out;
                        if (round_q == 4'd10) begin
                            {w_0, w_1, w_2, w_3} <= round_out;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            round_q <= 4'd0;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule
